// File: rtl/dht11_uart_reporter.sv
// -----------------------------------------------------------------------------
// dht11_uart_reporter
//
// Takes one decoded DHT11 frame per valid/ready handshake, checks its
// checksum and sends a fixed 6-byte report as 8N1 serial on uart_tx,
// LSB first.
//   byte 0 : SYNC_BYTE
//   byte 1..4 : hum_int, hum_dec, temp_int, temp_dec (zero on sensor timeout)
//   byte 5 : status (8'h00 ok, 8'hE1 checksum error, 8'hE2 sensor timeout)
//
// Ports
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   frame_valid   upstream offers frame_data / frame_timeout
//   frame_ready   high only while idle; accept on frame_valid && frame_ready
//   frame_data    {hum_int, hum_dec, temp_int, temp_dec, checksum}
//   frame_timeout upstream read failed; only meaningful with frame_valid
//   uart_tx       registered serial line, idle high
//   busy          high from acceptance until the packet is complete
//   pkt_done      one-cycle pulse after the last stop bit
//   chk_err       one-cycle pulse with pkt_done when status was 8'hE1
// -----------------------------------------------------------------------------
module dht11_uart_reporter #(
    parameter int          CLK_FREQ  = 100000000,
    parameter int          BAUD_RATE = 9600,
    parameter logic [7:0]  SYNC_BYTE = 8'hAA
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_valid,
    output logic        frame_ready,
    input  logic [39:0] frame_data,
    input  logic        frame_timeout,
    output logic        uart_tx,
    output logic        busy,
    output logic        pkt_done,
    output logic        chk_err
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    // A one-clock bit period would need a zero-width counter; keep at least 1 bit.
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    localparam logic [7:0] STATUS_OK      = 8'h00;
    localparam logic [7:0] STATUS_CHK_ERR = 8'hE1;
    localparam logic [7:0] STATUS_TIMEOUT = 8'hE2;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t             state_reg;
    logic [BAUD_W-1:0]  baud_cnt_reg;
    logic [2:0]         bit_idx_reg;
    logic [2:0]         byte_idx_reg;
    logic [47:0]        pkt_reg;       // byte k of the packet lives in [8k+7:8k]
    logic [6:0]         shift_reg;     // remaining data bits of the current byte
    logic               uart_tx_reg;
    logic               frame_ready_reg;
    logic               busy_reg;
    logic               pkt_done_reg;
    logic               chk_err_reg;

    // -------------------------------------------------------------------------
    // Frame decode and packet assembly (combinational, captured on acceptance)
    // -------------------------------------------------------------------------
    logic [7:0]  rx_byte [4];          // hum_int, hum_dec, temp_int, temp_dec
    logic [7:0]  rx_checksum;
    logic [7:0]  sum_next;
    logic        sum_ok;
    logic [7:0]  status_next;
    logic [47:0] pkt_next;

    assign rx_checksum = frame_data[7:0];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_payload
            assign rx_byte[gi] = frame_data[39 - 8*gi -: 8];
            // A timed-out read carries no trustworthy data, so it is zeroed.
            assign pkt_next[8*(gi+1) +: 8] = frame_timeout ? 8'h00 : rx_byte[gi];
        end
    endgenerate

    // 8-bit wrap-around sum, as the DHT11 itself computes it.
    assign sum_next = rx_byte[0] + rx_byte[1] + rx_byte[2] + rx_byte[3];
    assign sum_ok   = (sum_next == rx_checksum);

    always_comb begin
        status_next = STATUS_OK;
        if (frame_timeout) begin
            status_next = STATUS_TIMEOUT;
        end else if (!sum_ok) begin
            status_next = STATUS_CHK_ERR;
        end
    end

    assign pkt_next[7:0]   = SYNC_BYTE;
    assign pkt_next[47:40] = status_next;

    // -------------------------------------------------------------------------
    // Current byte select
    // -------------------------------------------------------------------------
    logic [7:0] cur_byte;

    always_comb begin
        cur_byte = pkt_reg[7:0];
        case (byte_idx_reg)
            3'd0:    cur_byte = pkt_reg[7:0];
            3'd1:    cur_byte = pkt_reg[15:8];
            3'd2:    cur_byte = pkt_reg[23:16];
            3'd3:    cur_byte = pkt_reg[31:24];
            3'd4:    cur_byte = pkt_reg[39:32];
            3'd5:    cur_byte = pkt_reg[47:40];
            default: cur_byte = pkt_reg[7:0];
        endcase
    end

    logic baud_last;
    assign baud_last = (baud_cnt_reg == BAUD_LAST);

    // -------------------------------------------------------------------------
    // Transmit FSM. Every output is registered here so uart_tx never glitches
    // and each bit period is exactly CLKS_PER_BIT cycles, including the
    // first start bit which appears the cycle after acceptance.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            baud_cnt_reg    <= '0;
            bit_idx_reg     <= '0;
            byte_idx_reg    <= '0;
            pkt_reg         <= '0;
            shift_reg       <= '0;
            uart_tx_reg     <= 1'b1;
            frame_ready_reg <= 1'b1;
            busy_reg        <= 1'b0;
            pkt_done_reg    <= 1'b0;
            chk_err_reg     <= 1'b0;
        end else begin
            pkt_done_reg <= 1'b0;
            chk_err_reg  <= 1'b0;

            case (state_reg)
                IDLE: begin
                    // frame_ready is always high here, so valid alone accepts.
                    if (frame_valid) begin
                        pkt_reg         <= pkt_next;
                        state_reg       <= START;
                        uart_tx_reg     <= 1'b0;
                        baud_cnt_reg    <= '0;
                        bit_idx_reg     <= '0;
                        byte_idx_reg    <= '0;
                        frame_ready_reg <= 1'b0;
                        busy_reg        <= 1'b1;
                    end
                end

                START: begin
                    if (baud_last) begin
                        baud_cnt_reg <= '0;
                        bit_idx_reg  <= '0;
                        uart_tx_reg  <= cur_byte[0];
                        shift_reg    <= cur_byte[7:1];
                        state_reg    <= DATA;
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + BAUD_W'(1);
                    end
                end

                DATA: begin
                    if (baud_last) begin
                        baud_cnt_reg <= '0;
                        if (bit_idx_reg == 3'd7) begin
                            uart_tx_reg <= 1'b1;
                            state_reg   <= STOP;
                        end else begin
                            bit_idx_reg <= bit_idx_reg + 3'd1;
                            uart_tx_reg <= shift_reg[0];
                            shift_reg   <= {1'b0, shift_reg[6:1]};
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + BAUD_W'(1);
                    end
                end

                STOP: begin
                    if (baud_last) begin
                        baud_cnt_reg <= '0;
                        if (byte_idx_reg != 3'd5) begin
                            // Next start bit follows the stop bit with no gap.
                            byte_idx_reg <= byte_idx_reg + 3'd1;
                            bit_idx_reg  <= '0;
                            uart_tx_reg  <= 1'b0;
                            state_reg    <= START;
                        end else begin
                            byte_idx_reg    <= '0;
                            state_reg       <= IDLE;
                            frame_ready_reg <= 1'b1;
                            busy_reg        <= 1'b0;
                            pkt_done_reg    <= 1'b1;
                            chk_err_reg     <= (pkt_reg[47:40] == STATUS_CHK_ERR);
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + BAUD_W'(1);
                    end
                end

                default: begin
                    state_reg       <= IDLE;
                    uart_tx_reg     <= 1'b1;
                    frame_ready_reg <= 1'b1;
                    busy_reg        <= 1'b0;
                end
            endcase
        end
    end

    assign uart_tx     = uart_tx_reg;
    assign frame_ready = frame_ready_reg;
    assign busy        = busy_reg;
    assign pkt_done    = pkt_done_reg;
    assign chk_err     = chk_err_reg;

endmodule

// File: tb/tb_dht11_uart_reporter.sv
// -----------------------------------------------------------------------------
// Testbench for dht11_uart_reporter (CLK_FREQ=1000, BAUD_RATE=100 -> 10
// clocks per bit, 600 clocks per packet). Expected packets are pushed into
// queues when a frame is offered; independent monitors decode uart_tx and
// watch pkt_done/chk_err and compare against the queues.
// -----------------------------------------------------------------------------
module tb_dht11_uart_reporter;

    localparam int CPB = 10;

    logic        clk;
    logic        rst_n;
    logic        frame_valid;
    logic        frame_ready;
    logic [39:0] frame_data;
    logic        frame_timeout;
    logic        uart_tx;
    logic        busy;
    logic        pkt_done;
    logic        chk_err;

    dht11_uart_reporter #(
        .CLK_FREQ  (1000),
        .BAUD_RATE (100),
        .SYNC_BYTE (8'hAA)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .frame_valid   (frame_valid),
        .frame_ready   (frame_ready),
        .frame_data    (frame_data),
        .frame_timeout (frame_timeout),
        .uart_tx       (uart_tx),
        .busy          (busy),
        .pkt_done      (pkt_done),
        .chk_err       (chk_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int cyc      = 0;
    int rst_count = 0;
    int byte_no  = 0;

    logic [7:0] exp_byte_q[$];
    logic       exp_chk_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Watchdog: bound the whole run.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cyc > 30000) begin
            $display("FAIL watchdog: simulation exceeded cycle budget");
            $fatal(1);
        end
    end

    always @(negedge rst_n) rst_count++;

    // Expected packet: first byte in the MSBs.
    task automatic push_pkt(input logic [47:0] bytes, input logic chk);
        for (int i = 5; i >= 0; i--) begin
            exp_byte_q.push_back(bytes[8*i +: 8]);
        end
        exp_chk_q.push_back(chk);
    endtask

    // -------------------------------------------------------------------------
    // UART monitor: start detected at first low sample, then mid-bit samples.
    // -------------------------------------------------------------------------
    initial begin
        int         rc;
        logic [7:0] b;
        logic       st_bit;
        logic       sp_bit;
        logic [7:0] eb;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && uart_tx === 1'b0) begin
                rc = rst_count;
                repeat (4) @(negedge clk);
                st_bit = uart_tx;
                for (int k = 0; k < 8; k++) begin
                    repeat (CPB) @(negedge clk);
                    b[k] = uart_tx;
                end
                repeat (CPB) @(negedge clk);
                sp_bit = uart_tx;
                if (rc == rst_count && rst_n === 1'b1) begin
                    $display("uart byte %0d: %02h", byte_no, b);
                    byte_no++;
                    check("start_bit", st_bit, 1'b0);
                    check("stop_bit", sp_bit, 1'b1);
                    check("byte_expected", exp_byte_q.size() != 0, 1'b1);
                    if (exp_byte_q.size() != 0) begin
                        eb = exp_byte_q.pop_front();
                        check("uart_byte", b, eb);
                    end
                end else begin
                    $display("uart byte aborted by reset");
                end
            end
        end
    end

    // Completion monitor.
    initial begin
        logic ec;
        forever begin
            @(negedge clk);
            if (pkt_done === 1'b1 || chk_err === 1'b1) begin
                $display("pkt_done chk_err=%0b", chk_err);
                check("pkt_done_with_chk", pkt_done, 1'b1);
                check("pkt_done_expected", exp_chk_q.size() != 0, 1'b1);
                if (exp_chk_q.size() != 0) begin
                    ec = exp_chk_q.pop_front();
                    check("chk_err", chk_err, ec);
                end
            end
        end
    end

    // Offer a frame at a negedge; returns right after the accepting posedge.
    task automatic offer(input logic [39:0] d, input logic to);
        int n;
        frame_data    = d;
        frame_timeout = to;
        frame_valid   = 1'b1;
        n = 0;
        while (frame_ready !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("accept_in_time", frame_ready, 1'b1);
        @(posedge clk);
    endtask

    task automatic wait_done(input int max_cyc);
        int n;
        n = 0;
        while (pkt_done !== 1'b1 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check("pkt_done_in_time", pkt_done, 1'b1);
        @(negedge clk);
    endtask

    initial begin
        int pulses;
        int txlow;
        int rdy_hi;

        rst_n         = 1'b0;
        frame_valid   = 1'b0;
        frame_data    = '0;
        frame_timeout = 1'b0;

        // ---- 1: reset state and idle ----
        repeat (3) @(negedge clk);
        check("rst_uart_tx", uart_tx, 1'b1);
        check("rst_frame_ready", frame_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_pkt_done", pkt_done, 1'b0);
        check("rst_chk_err", chk_err, 1'b0);
        rst_n = 1'b1;
        pulses = 0;
        txlow  = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (pkt_done || chk_err) pulses++;
            if (!uart_tx || !frame_ready || busy) txlow++;
        end
        check("idle_no_pulses", pulses, 0);
        check("idle_line_state", txlow, 0);

        // ---- 2: good frame, exact latency ----
        push_pkt(48'hAA2D00170000, 1'b0);
        @(negedge clk);
        offer(40'h2D00170044, 1'b0);
        @(negedge clk);                       // T+1
        frame_valid = 1'b0;
        check("t2_start_bit_tx", uart_tx, 1'b0);
        check("t2_busy", busy, 1'b1);
        check("t2_ready_low", frame_ready, 1'b0);
        repeat (599) @(negedge clk);          // T+600
        check("t2_done_not_early", pkt_done, 1'b0);
        @(negedge clk);                       // T+601
        check("t2_done_at_601", pkt_done, 1'b1);
        check("t2_ready_back", frame_ready, 1'b1);
        check("t2_busy_clear", busy, 1'b0);
        @(negedge clk);
        check("t2_done_one_cycle", pkt_done, 1'b0);
        repeat (5) @(negedge clk);

        // ---- 3: bad checksum ----
        push_pkt(48'hAA2D001700E1, 1'b1);
        offer(40'h2D00170045, 1'b0);
        @(negedge clk);
        frame_valid = 1'b0;
        wait_done(700);
        repeat (5) @(negedge clk);

        // ---- 4: sensor timeout overrides data ----
        push_pkt(48'hAA00000000E2, 1'b0);
        offer(40'hFFFFFFFFFF, 1'b1);
        @(negedge clk);
        frame_valid   = 1'b0;
        frame_timeout = 1'b0;
        wait_done(700);
        repeat (5) @(negedge clk);

        // ---- 5: back-to-back with valid held, data toggled mid-packet ----
        push_pkt(48'hAA2D00170000, 1'b0);
        push_pkt(48'hAA3C05190000, 1'b0);
        offer(40'h2D00170044, 1'b0);
        rdy_hi = 0;
        for (int i = 1; i <= 600; i++) begin
            @(negedge clk);
            if (frame_ready) rdy_hi++;
            if (i == 50) begin
                frame_data    = 40'hFFFFFFFFFF;
                frame_timeout = 1'b1;
            end
            if (i == 200) begin
                frame_data    = 40'h3C0519005A;
                frame_timeout = 1'b0;
            end
        end
        check("t5_ready_low_in_pkt", rdy_hi, 0);
        @(negedge clk);                       // A's pkt_done cycle
        check("t5_a_done", pkt_done, 1'b1);
        check("t5_gap_tx_high", uart_tx, 1'b1);
        @(negedge clk);                       // B accepted on previous edge
        frame_valid = 1'b0;
        check("t5_b_start_bit", uart_tx, 1'b0);
        check("t5_b_busy", busy, 1'b1);
        wait_done(700);
        repeat (5) @(negedge clk);

        // ---- 6: reset during byte 3 data (bit 3 of 0x17 is 0) ----
        push_pkt(48'hAA2D00170000, 1'b0);
        offer(40'h2D00170044, 1'b0);
        @(negedge clk);                       // T+1
        frame_valid = 1'b0;
        repeat (344) @(negedge clk);          // T+345, mid bit 3 of byte 3
        check("t6_pre_reset_tx", uart_tx, 1'b0);
        rst_n = 1'b0;
        #1;
        check("t6_reset_tx_high", uart_tx, 1'b1);
        check("t6_reset_busy", busy, 1'b0);
        check("t6_reset_ready", frame_ready, 1'b1);
        exp_byte_q.delete();
        exp_chk_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (150) @(negedge clk);
        push_pkt(48'hAA2D001700E1, 1'b1);
        offer(40'h2D00170045, 1'b0);
        @(negedge clk);
        frame_valid = 1'b0;
        wait_done(700);

        repeat (20) @(negedge clk);
        check("all_bytes_seen", exp_byte_q.size(), 0);
        check("all_pkts_seen", exp_chk_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/dht11_uart_reporter.md
Name: dht11_uart_reporter

Overview:
Downstream consumer of the DHT11 sensor reader. It accepts one decoded 40-bit DHT11 frame per valid/ready handshake and validates the checksum. It then transmits a fixed 6-byte report packet on uart_tx as 8N1 serial, LSB first. It owns the only UART transmitter in the sensor path; the reader block drives frame_* and never touches uart_tx.

Parameters:
CLK_FREQ, 100000000, system clock frequency in Hz
BAUD_RATE, 9600, UART bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer division, 10416 at defaults)
SYNC_BYTE, 8'hAA, first byte of every packet

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  reset, asynchronous, active-low
frame_valid  input  1  upstream offers frame_data/frame_timeout
frame_ready  output  1  high only in IDLE; frame accepted on cycle with frame_valid && frame_ready
frame_data  input  40  [39:32] hum_int, [31:24] hum_dec, [23:16] temp_int, [15:8] temp_dec, [7:0] checksum
frame_timeout  input  1  upstream read failed (sensor timeout); qualified by frame_valid
uart_tx  output  1  serial line, idle high
busy  output  1  high from acceptance until packet complete
pkt_done  output  1  one-cycle pulse when last stop bit ends
chk_err  output  1  one-cycle pulse, coincident with pkt_done, when the sent packet carried status 8'hE1

Behaviour:
- Reset (async): state IDLE, uart_tx=1, frame_ready=1, busy=0, pkt_done=0, chk_err=0. All counters cleared. Reset mid-packet abandons the packet; uart_tx goes high immediately.
- Checksum: ok when (hum_int+hum_dec+temp_int+temp_dec) mod 256 == checksum, using an 8-bit wrap-around sum.
- Packet is built at acceptance into a 48-bit register: SYNC_BYTE, b1, b2, b3, b4, status. Later changes on frame_data are ignored.
  - frame_timeout=1: status 8'hE2, b1..b4 = 8'h00. Timeout takes priority over the checksum result.
  - checksum bad: status 8'hE1, b1..b4 = received bytes as-is.
  - otherwise: status 8'h00, b1..b4 = hum_int, hum_dec, temp_int, temp_dec.
- FSM:
  - IDLE -> START on acceptance.
  - START drives uart_tx=0 for CLKS_PER_BIT cycles, then -> DATA.
  - DATA sends 8 bits LSB first, each CLKS_PER_BIT cycles, then -> STOP.
  - STOP drives uart_tx=1 for CLKS_PER_BIT cycles. If byte_idx<5: byte_idx++ and -> START, with no idle gap between bytes. Else -> IDLE.
- Timing: the start bit of byte 0 appears on uart_tx the cycle after acceptance. The packet occupies exactly 60*CLKS_PER_BIT cycles. uart_tx is registered (glitch-free).
- Completion: on the cycle after the last stop-bit period, state=IDLE, frame_ready=1, busy=0, pkt_done=1 (and chk_err if applicable), for one cycle only.
- frame_valid while busy: not accepted; upstream must hold. frame_valid during the pkt_done cycle is accepted (ready=1), giving back-to-back packets with one idle-high cycle between them.
- Counters:
  - baud counter width $clog2(CLKS_PER_BIT), wraps at CLKS_PER_BIT-1.
  - bit_idx 0..7.
  - byte_idx 0..5.
  - Wrap-around beyond these ranges must not occur.
- frame_valid and frame_timeout are synchronous to clk, no synchronizer needed. frame_timeout is ignored when frame_valid=0.

Test Plan:
Bench uses CLK_FREQ=1000 and BAUD_RATE=100, so CLKS_PER_BIT=10 and a packet is 600 cycles.
1. Reset then idle 50 cycles -> uart_tx=1, frame_ready=1, busy=0, no pulses.
2. Frame 40'h2D00170044 (45%, 23C, checksum 0x44 ok), accept at cycle T -> uart_tx=0 at T+1. Decoded bytes AA 2D 00 17 00 00. pkt_done at T+601, chk_err=0.
3. Frame 40'h2D00170045 (bad checksum) -> bytes AA 2D 00 17 00 E1, chk_err=1 with pkt_done.
4. frame_timeout=1 with frame_data=40'hFFFFFFFFFF -> bytes AA 00 00 00 00 E2, chk_err=0.
5. Hold frame_valid high continuously with frame A then B -> B accepted exactly on A's pkt_done cycle. frame_data toggled mid-packet does not alter A's bytes. frame_ready=0 throughout each packet.
6. Assert rst_n low during byte 3 data bits -> uart_tx=1 same cycle, busy=0. After release, a new frame is sent complete and correct.
